multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: opcode  in  7  instruction bits [6:0] from the instruction register.
REQ-004 SHALL: funct3  in  3  instruction bits [14:12].
REQ-005 SHALL: funct7_5  in  1  instruction bit 30.
REQ-006 SHALL: zero  in  1  ALU zero flag.
REQ-007 SHALL: mem_ready  in  1  memory access-complete handshake.
REQ-008 SHALL: pc_write, ir_write, mem_write, reg_write, adr_src  out  1 each  datapath enables/select.
REQ-009 SHALL: alu_src_a  out  2  select: 00 PC, 01 old_pc, 10 rs1 register.
REQ-010 SHALL: alu_src_b  out  2  select: 00 rs2 register, 01 immediate, 10 constant 4.
REQ-011 SHALL: result_src  out  2  select: 00 ALUOut register, 01 memory-data register, 10 live ALU result, 11 immediate.
REQ-012 SHALL: imm_src  out  3  select: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-013 SHALL: alu_function  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 set-less-than.
REQ-014 SHALL: illegal_instr, retire  out  1 each  single-cycle status pulses.

Function
REQ-015 SHALL: implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, JALR_PC, LUI.
REQ-016 SHALL: in FETCH, drive adr_src=0, A=00, B=10, add, result_src=10; ir_write and pc_write=1 only while mem_ready=1; remain in FETCH while mem_ready=0.
REQ-017 SHALL: in DECODE, drive A=01, B=01, add, with imm_src taken from opcode; ALUOut then holds old_pc+imm.
REQ-018 SHALL: from DECODE, go to MEMADR for lw (0000011) and sw (0100011), EXEC_R for 0110011, EXEC_I for 0010011, BRANCH for 1100011, JAL for 1101111, JALR for 1100111, LUI for 0110111.
REQ-019 SHALL: for any other opcode, or an unsupported funct3 value, pulse illegal_instr in DECODE, perform no writes, and return to FETCH.
REQ-020 SHALL: MEMADR computes rs1+imm (A=10, B=01, add) and goes to MEMREAD for lw or MEMWRITE for sw.
REQ-021 SHALL: MEMREAD (adr_src=1) and MEMWRITE (adr_src=1, mem_write=1) hold their state until mem_ready=1, then MEMREAD goes to MEMWB and MEMWRITE goes to FETCH.
REQ-022 SHALL: MEMWB drives result_src=01 and reg_write=1.
REQ-023 SHALL: EXEC_R and EXEC_I drive A=10 with B=00 (R) or B=01 (I), then go to ALUWB; ALUWB drives result_src=00 and reg_write=1.
REQ-024 SHALL: R-type ALU decode: funct3 000 gives sub if funct7_5=1, else add; 111 gives and; 110 gives or; 010 gives slt. I-type uses the same mapping except funct3 000 always gives add.
REQ-025 SHALL: BRANCH drives A=10, B=00, result_src=00, and asserts pc_write when taken: beq (000) uses sub and branches if zero; bne (001) uses sub and branches if !zero; blt (100) uses slt and branches if !zero; bge (101) uses slt and branches if zero.
REQ-026 SHALL: JAL drives result_src=00, pc_write=1, A=01, B=10, add, then goes to ALUWB.
REQ-027 SHALL: JALR computes rs1+imm; JALR_PC then drives result_src=00, pc_write=1, A=01, B=10, add, then goes to ALUWB.
REQ-028 SHALL: LUI drives imm_src=100, result_src=11, reg_write=1.
REQ-029 SHALL: every enable not listed for a state is 0; alu_function defaults to 000 (add).
REQ-030 SHALL: pulse retire in the final state of each instruction (MEMWB, MEMWRITE on exit, ALUWB, BRANCH, LUI), then go to FETCH.
REQ-031 SHALL: instruction latencies with zero wait states: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3 cycles.

Reset
REQ-032 SHALL: while rst=1, force all enables and pulses to 0; the next state is FETCH.
REQ-033 SHALL: rst asserted mid-instruction, including during a memory wait, abandons that instruction with no write in the reset cycle.

Structure
REQ-034 SHALL: a shared package holds the state encoding, opcode constants, alu_function codes and the mux-select codes.
REQ-035 SHALL: ALU-operation selection lives in a combinational sub-module named alu_decoder.

Verification
REQ-036 SHALL: add (funct7_5=0), mem_ready=1 -> FETCH, DECODE, EXEC_R, ALUWB; alu_function 000; reg_write only in cycle 4; retire in cycle 4.
REQ-037 SHALL: lw with mem_ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles with adr_src=1 throughout, then MEMWB with result_src=01.
REQ-038 SHALL: bne with zero=0, then beq with zero=0 -> pc_write=1 in BRANCH for bne, 0 for beq; both use alu_function 001.
REQ-039 SHALL: opcode 1111111 -> illegal_instr=1 for one cycle in DECODE, no writes, back to FETCH.
REQ-040 SHALL: jalr -> pc_write in JALR_PC, reg_write in ALUWB, 5 cycles total.
REQ-041 SHALL: rst asserted during MEMWRITE -> mem_write=0 in the reset cycle and FETCH on the next cycle.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: FSM states,
// opcodes, ALU operation codes, datapath mux selects and decode helpers.
package multi_cycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_LUI
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_R,
        ALUOP_I,
        ALUOP_BRANCH
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // An instruction is legal only if both its opcode and funct3 are implemented.
    function automatic logic instr_legal(input logic [6:0] opcode, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE: ok = (funct3 == 3'b010);
            OP_R, OP_I:        ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                                    (funct3 == 3'b110) || (funct3 == 3'b010);
            OP_BRANCH:         ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                                    (funct3 == 3'b100) || (funct3 == 3'b101);
            OP_JALR:           ok = (funct3 == 3'b000);
            OP_JAL, OP_LUI:    ok = 1'b1;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
        logic [2:0] sel;
        sel = IMM_I;
        case (opcode)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            OP_LUI:    sel = IMM_U;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// Combinational ALU operation decode from the FSM's operation class plus
// funct3/funct7_5. Unused combinations fall back to add.
module alu_decoder
    import multi_cycle_controller_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_function
);

    always_comb begin
        alu_function = ALU_ADD;
        case (alu_op)
            ALUOP_R, ALUOP_I: begin
                case (funct3)
                    // Immediate form has no subtract: bit 30 belongs to the immediate.
                    3'b000:  alu_function = (alu_op == ALUOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_function = ALU_AND;
                    3'b110:  alu_function = ALU_OR;
                    3'b010:  alu_function = ALU_SLT;
                    default: alu_function = ALU_ADD;
                endcase
            end
            ALUOP_BRANCH: alu_function = funct3[2] ? ALU_SLT : ALU_SUB;
            default:      alu_function = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V control FSM: sequences fetch, decode and execute states
// and drives datapath enables/selects; reset suppresses every write.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [2:0] alu_function,
    output logic       illegal_instr,
    output logic       retire
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    branch_taken;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = !zero;
            3'b101:  branch_taken = zero;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        alu_op        = ALUOP_ADD;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_src    = RES_ALUOUT;
        imm_src       = IMM_I;
        illegal_instr = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_src   = imm_sel(opcode);
                if (!instr_legal(opcode, funct3)) begin
                    illegal_instr = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXEC_R;
                        OP_I:              state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI:            state_d = S_LUI;
                        default:           state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_src   = imm_sel(opcode);
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_op    = ALUOP_R;
                alu_src_a = SRC_A_RS1;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_op    = ALUOP_I;
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op    = ALUOP_BRANCH;
                alu_src_a = SRC_A_RS1;
                pc_write  = branch_taken;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            // Jumps: ALUOut already holds the target; recompute old_pc+4 as the link.
            S_JAL, S_JALR_PC: begin
                pc_write  = 1'b1;
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_FOUR;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = S_JALR_PC;
            end
            S_LUI: begin
                imm_src    = IMM_U;
                result_src = RES_IMM;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            state_d       = S_FETCH;
            alu_op        = ALUOP_ADD;
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            adr_src       = 1'b0;
            alu_src_a     = SRC_A_PC;
            alu_src_b     = SRC_B_RS2;
            result_src    = RES_ALUOUT;
            imm_src       = IMM_I;
            illegal_instr = 1'b0;
            retire        = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op       (alu_op),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .alu_function (alu_function)
    );

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: each stimulus cycle queues its hand-computed control word;
// a negedge monitor pops and compares against the DUT outputs.
module tb_multi_cycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src, alu_function;
    logic       illegal_instr, retire;

    multi_cycle_controller dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .adr_src       (adr_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .imm_src       (imm_src),
        .alu_function  (alu_function),
        .illegal_instr (illegal_instr),
        .retire        (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    int   popped = 0;

    // Word layout: pcw irw mw rw adr | A | B | res | imm | alu | ill ret
    function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic mw,
                                       input logic rw, input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs,
                                       input logic [2:0] imm, input logic [2:0] af,
                                       input logic ill, input logic ret);
        return {pcw, irw, mw, rw, adr, a, b, rs, imm, af, ill, ret};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [18:0] act;
            e   = q.pop_front();
            act = {pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
                   result_src, imm_src, alu_function, illegal_instr, retire};
            popped++;
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got=%b want=%b", e.tag, act, e.v);
            end else begin
                $display("ok   %s: %b", e.tag, act);
            end
        end
    end

    task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic z, input logic mr,
                        input logic [18:0] ev, input string tag);
        exp_t e;
        rst       = r;
        opcode    = op;
        funct3    = f3;
        funct7_5  = f7;
        zero      = z;
        mem_ready = mr;
        e.v   = ev;
        e.tag = tag;
        q.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
    endtask

    logic [18:0] W_ZERO, W_FETCH, W_FETCH_WAIT, W_DEC_I, W_DEC_S, W_DEC_B, W_DEC_J, W_DEC_U;
    logic [18:0] W_DEC_ILL, W_RS1_IMM, W_ALUWB, W_MEMREAD, W_MEMWB, W_JUMP, W_LUI;

    initial begin
        W_ZERO       = '0;
        W_FETCH      = mk(1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0, 0);
        W_FETCH_WAIT = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0, 0);
        W_DEC_I      = mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0);
        W_DEC_S      = mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b001, 3'b000, 0, 0);
        W_DEC_B      = mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 3'b000, 0, 0);
        W_DEC_J      = mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b011, 3'b000, 0, 0);
        W_DEC_U      = mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b100, 3'b000, 0, 0);
        W_DEC_ILL    = mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 1, 0);
        W_RS1_IMM    = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 0, 0);
        W_ALUWB      = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1);
        W_MEMREAD    = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0);
        W_MEMWB      = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 0, 1);
        W_JUMP       = mk(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0);
        W_LUI        = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b11, 3'b100, 3'b000, 0, 1);

        rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1, 7'b0000000, 3'b000, 0, 0, 1, W_ZERO, "reset");

        // add: 4 cycles, fetch stall first
        step(0, 7'b0110011, 3'b000, 0, 0, 0, W_FETCH_WAIT, "add fetch wait");
        step(0, 7'b0110011, 3'b000, 0, 0, 1, W_FETCH, "add fetch");
        step(0, 7'b0110011, 3'b000, 0, 0, 1, W_DEC_I, "add decode");
        step(0, 7'b0110011, 3'b000, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,3'b000,0,0), "add exec");
        step(0, 7'b0110011, 3'b000, 0, 0, 1, W_ALUWB, "add aluwb");

        // sub, and, or, slt exec words
        step(0, 7'b0110011, 3'b000, 1, 0, 1, W_FETCH, "sub fetch");
        step(0, 7'b0110011, 3'b000, 1, 0, 1, W_DEC_I, "sub decode");
        step(0, 7'b0110011, 3'b000, 1, 0, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,3'b001,0,0), "sub exec");
        step(0, 7'b0110011, 3'b000, 1, 0, 1, W_ALUWB, "sub aluwb");
        step(0, 7'b0110011, 3'b110, 0, 0, 1, W_FETCH, "or fetch");
        step(0, 7'b0110011, 3'b110, 0, 0, 1, W_DEC_I, "or decode");
        step(0, 7'b0110011, 3'b110, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,3'b011,0,0), "or exec");
        step(0, 7'b0110011, 3'b110, 0, 0, 1, W_ALUWB, "or aluwb");
        step(0, 7'b0110011, 3'b010, 0, 0, 1, W_FETCH, "slt fetch");
        step(0, 7'b0110011, 3'b010, 0, 0, 1, W_DEC_I, "slt decode");
        step(0, 7'b0110011, 3'b010, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,3'b100,0,0), "slt exec");
        step(0, 7'b0110011, 3'b010, 0, 0, 1, W_ALUWB, "slt aluwb");

        // addi with bit30 set stays add; andi gives and
        step(0, 7'b0010011, 3'b000, 1, 0, 1, W_FETCH, "addi fetch");
        step(0, 7'b0010011, 3'b000, 1, 0, 1, W_DEC_I, "addi decode");
        step(0, 7'b0010011, 3'b000, 1, 0, 1, W_RS1_IMM, "addi exec");
        step(0, 7'b0010011, 3'b000, 1, 0, 1, W_ALUWB, "addi aluwb");
        step(0, 7'b0010011, 3'b111, 0, 0, 1, W_FETCH, "andi fetch");
        step(0, 7'b0010011, 3'b111, 0, 0, 1, W_DEC_I, "andi decode");
        step(0, 7'b0010011, 3'b111, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,3'b010,0,0), "andi exec");
        step(0, 7'b0010011, 3'b111, 0, 0, 1, W_ALUWB, "andi aluwb");

        // lw with two wait cycles in MEMREAD
        step(0, 7'b0000011, 3'b010, 0, 0, 1, W_FETCH, "lw fetch");
        step(0, 7'b0000011, 3'b010, 0, 0, 1, W_DEC_I, "lw decode");
        step(0, 7'b0000011, 3'b010, 0, 0, 1, W_RS1_IMM, "lw memadr");
        step(0, 7'b0000011, 3'b010, 0, 0, 0, W_MEMREAD, "lw memread wait1");
        step(0, 7'b0000011, 3'b010, 0, 0, 0, W_MEMREAD, "lw memread wait2");
        step(0, 7'b0000011, 3'b010, 0, 0, 1, W_MEMREAD, "lw memread done");
        step(0, 7'b0000011, 3'b010, 0, 0, 1, W_MEMWB, "lw memwb");

        // sw, zero wait states
        step(0, 7'b0100011, 3'b010, 0, 0, 1, W_FETCH, "sw fetch");
        step(0, 7'b0100011, 3'b010, 0, 0, 1, W_DEC_S, "sw decode");
        step(0, 7'b0100011, 3'b010, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b01,2'b00,3'b001,3'b000,0,0), "sw memadr");
        step(0, 7'b0100011, 3'b010, 0, 0, 1, mk(0,0,1,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0,1), "sw memwrite");

        // bne taken, beq not taken, blt taken, bge not taken (all with zero=0)
        step(0, 7'b1100011, 3'b001, 0, 0, 1, W_FETCH, "bne fetch");
        step(0, 7'b1100011, 3'b001, 0, 0, 1, W_DEC_B, "bne decode");
        step(0, 7'b1100011, 3'b001, 0, 0, 1, mk(1,0,0,0,0,2'b10,2'b00,2'b00,3'b000,3'b001,0,1), "bne branch");
        step(0, 7'b1100011, 3'b000, 0, 0, 1, W_FETCH, "beq fetch");
        step(0, 7'b1100011, 3'b000, 0, 0, 1, W_DEC_B, "beq decode");
        step(0, 7'b1100011, 3'b000, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,3'b001,0,1), "beq branch");
        step(0, 7'b1100011, 3'b100, 0, 0, 1, W_FETCH, "blt fetch");
        step(0, 7'b1100011, 3'b100, 0, 0, 1, W_DEC_B, "blt decode");
        step(0, 7'b1100011, 3'b100, 0, 0, 1, mk(1,0,0,0,0,2'b10,2'b00,2'b00,3'b000,3'b100,0,1), "blt branch");
        step(0, 7'b1100011, 3'b101, 0, 0, 1, W_FETCH, "bge fetch");
        step(0, 7'b1100011, 3'b101, 0, 0, 1, W_DEC_B, "bge decode");
        step(0, 7'b1100011, 3'b101, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,3'b100,0,1), "bge branch");

        // illegal opcode, then illegal funct3 on an R-type
        step(0, 7'b1111111, 3'b000, 0, 0, 1, W_FETCH, "illop fetch");
        step(0, 7'b1111111, 3'b000, 0, 0, 1, W_DEC_ILL, "illop decode");
        step(0, 7'b0110011, 3'b001, 0, 0, 1, W_FETCH, "illf3 fetch");
        step(0, 7'b0110011, 3'b001, 0, 0, 1, W_DEC_ILL, "illf3 decode");

        // jal, jalr, lui
        step(0, 7'b1101111, 3'b000, 0, 0, 1, W_FETCH, "jal fetch");
        step(0, 7'b1101111, 3'b000, 0, 0, 1, W_DEC_J, "jal decode");
        step(0, 7'b1101111, 3'b000, 0, 0, 1, W_JUMP, "jal jump");
        step(0, 7'b1101111, 3'b000, 0, 0, 1, W_ALUWB, "jal aluwb");
        step(0, 7'b1100111, 3'b000, 0, 0, 1, W_FETCH, "jalr fetch");
        step(0, 7'b1100111, 3'b000, 0, 0, 1, W_DEC_I, "jalr decode");
        step(0, 7'b1100111, 3'b000, 0, 0, 1, W_RS1_IMM, "jalr target");
        step(0, 7'b1100111, 3'b000, 0, 0, 1, W_JUMP, "jalr pc");
        step(0, 7'b1100111, 3'b000, 0, 0, 1, W_ALUWB, "jalr aluwb");
        step(0, 7'b0110111, 3'b000, 0, 0, 1, W_FETCH, "lui fetch");
        step(0, 7'b0110111, 3'b000, 0, 0, 1, W_DEC_U, "lui decode");
        step(0, 7'b0110111, 3'b000, 0, 0, 1, W_LUI, "lui wb");

        // reset during a stalled MEMWRITE abandons the store
        step(0, 7'b0100011, 3'b010, 0, 0, 1, W_FETCH, "swr fetch");
        step(0, 7'b0100011, 3'b010, 0, 0, 1, W_DEC_S, "swr decode");
        step(0, 7'b0100011, 3'b010, 0, 0, 1, mk(0,0,0,0,0,2'b10,2'b01,2'b00,3'b001,3'b000,0,0), "swr memadr");
        step(0, 7'b0100011, 3'b010, 0, 0, 0, mk(0,0,1,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0,0), "swr memwrite wait");
        step(1, 7'b0100011, 3'b010, 0, 0, 0, W_ZERO, "swr reset cycle");
        step(0, 7'b0100011, 3'b010, 0, 0, 1, W_FETCH, "swr refetch");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0 || popped != pushed) begin
            bad++;
            $display("FAIL drain: checked=%0d required=%0d", popped, pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
